sseg_capture: RTL and testbench
===============================

# sseg_capture

Receive side of the multiplexed four-digit seven-segment interface. Samples the active-low anode and cathode lines driven by a display driver, decodes each digit, assembles a complete four-digit frame and reports it as BCD and binary with a one-cycle valid strobe. It sits at the board boundary or in the bench, observing the display bus, and is used to loop back displayed results for self-check.

## Interface
- SETTLE_CYCLES, 1024: number of consecutive cycles the synced anode/cathode bus must be unchanged before a digit is sampled (range 2..65535).
- TIMEOUT_CYCLES, 1048576: maximum number of cycles without a sampled digit before the display is declared blank (range 2..2^24).
- clock_100Mhz  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Anode_Activate_in  in  4  anode lines, active low; 0111 = thousands, 1011 = hundreds, 1101 = tens, 1110 = units.
- LED_in  in  7  cathode lines, active low, bit 6 = segment a ... bit 0 = segment g.
- captured_bcd  out  16  last accepted frame; [15:12] = thousands ... [3:0] = units.
- captured_number  out  14  binary value of captured_bcd, 0..9999.
- number_valid  out  1  one-cycle pulse when the captured_* outputs update.
- frame_error  out  1  one-cycle pulse when a frame is abandoned.
- display_blank  out  1  level; high while the timeout has expired.

## Operation
- Both input buses pass through a two-flop synchronizer. All logic below uses the synced values.
- Stability counter: cleared whenever the synced {anode, cathode} differs from the previous cycle. Otherwise it increments and saturates. Exactly one sample event occurs per dwell, on the cycle the counter reaches SETTLE_CYCLES-1.
- An anode value with zero low bits or more than one low bit is idle. It produces no sample and no error.
- Cathode decode (active low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100. Any other pattern is invalid.
- State machine:
  - WAIT_START: waits for a sample on the thousands position. A valid digit goes to COLLECT with expected = hundreds. Samples on other positions are ignored.
  - COLLECT: each sample must be on the expected position and carry a valid digit. A wrong position or an invalid pattern pulses frame_error and returns to WAIT_START. After the units digit it goes to CONVERT.
  - CONVERT: computes d3·1000 + d2·100 + d1·10 + d0 with shift-add arithmetic in 14 bits, loads the outputs and pulses number_valid, then returns to WAIT_START.
- Resampling the same position in COLLECT (a repeated dwell) counts as a wrong position.
- An invalid cathode pattern sampled in WAIT_START is ignored.
- Timeout counter: cleared on every sample event. When it reaches TIMEOUT_CYCLES, display_blank goes high and any state returns to WAIT_START without a frame_error. display_blank clears on the next sample event.
- captured_* keep their last accepted value across errors and timeouts.

## Timing
- Reset values: captured_bcd = 0, captured_number = 0, number_valid = 0, frame_error = 0, display_blank = 0. The FSM resets to WAIT_START and all counters to 0.
- Input-to-sample latency: 2 synchronizer cycles plus SETTLE_CYCLES-1 cycles of stability.
- If the units digit is sampled at cycle T: CONVERT at T+1; captured_* update and number_valid is high at T+2, for exactly one cycle.
- frame_error is high in the cycle after the offending sample.
- A sample and a timeout in the same cycle: the sample wins and the timeout counter clears.
- Reset mid-frame discards the partial frame. A full thousands-to-units sequence is required afterwards.

## Configuration
- SSEG_CAPTURE_CONSISTENCY_EN:
  - Defined: a converted frame is accepted only if it equals the previous converted frame. The first frame after reset, a timeout, or a changed value is held as a candidate only, so number_valid fires on the second identical consecutive frame. A mismatch replaces the candidate and raises no error.
  - Undefined: every complete frame is accepted.

## Structure
- Package sseg_pkg holds:
  - the ten cathode pattern constants and the blank pattern;
  - the anode one-hot-low constants;
  - the FSM state encoding (WAIT_START, COLLECT, CONVERT).
- Sub-module sseg_segment_decode: a combinational cathode → {valid, digit[3:0]} decoder. The driver side can later share it in reverse.

## Test plan
- Bench parameters for all scenarios: SETTLE_CYCLES = 16, TIMEOUT_CYCLES = 4096, 64-cycle dwell per digit.
- Frame "0123" → captured_bcd = 16'h0123, captured_number = 123, one number_valid pulse two cycles after the units sample.
- Frame "9999" → captured_number = 9999, captured_bcd = 16'h9999.
- Cathode 1111111 on the tens dwell of frame "4567" after a good "0123" → one frame_error pulse, no number_valid, captured_number stays 123.
- Anode order thousands, tens → frame_error. The next clean "0042" frame yields captured_number = 42.
- Anode held at 1111 for 5000 cycles → display_blank = 1 at cycle 4096 after the last sample, with no frame_error. The next digit sample clears it.
- reset_n low during the hundreds dwell → all outputs 0. A frame "0100" after release yields captured_number = 100.
- With SSEG_CAPTURE_CONSISTENCY_EN defined: frames "0123" then "0123" → a single number_valid, on the second frame.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants, bus payload and helpers for the seven-segment capture path.
package sseg_pkg;

    localparam int unsigned AN_W  = 4;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned DIG_W = 4;
    localparam int unsigned BCD_W = 16;
    localparam int unsigned BIN_W = 14;

    // Active-low cathode patterns, bit 6 = segment a ... bit 0 = segment g
    localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [AN_W-1:0] AN_THOUSANDS = 4'b0111;
    localparam logic [AN_W-1:0] AN_HUNDREDS  = 4'b1011;
    localparam logic [AN_W-1:0] AN_TENS      = 4'b1101;
    localparam logic [AN_W-1:0] AN_UNITS     = 4'b1110;
    localparam logic [AN_W-1:0] AN_IDLE      = 4'b1111;

    localparam logic [1:0] WAIT_START = 2'd0;
    localparam logic [1:0] COLLECT    = 2'd1;
    localparam logic [1:0] CONVERT    = 2'd2;

    typedef struct packed {
        logic [AN_W-1:0]  anode;
        logic [SEG_W-1:0] seg;
    } sseg_bus_t;

    // BCD to binary with shifts and adds only: 1000 = 512+256+128+64+32+8, 100 = 64+32+4, 10 = 8+2
    function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [BCD_W-1:0] bcd);
        logic [BIN_W-1:0] d3;
        logic [BIN_W-1:0] d2;
        logic [BIN_W-1:0] d1;
        logic [BIN_W-1:0] d0;
        d3 = BIN_W'(bcd[15:12]);
        d2 = BIN_W'(bcd[11:8]);
        d1 = BIN_W'(bcd[7:4]);
        d0 = BIN_W'(bcd[3:0]);
        return (d3 << 9) + (d3 << 8) + (d3 << 7) + (d3 << 6) + (d3 << 5) + (d3 << 3)
             + (d2 << 6) + (d2 << 5) + (d2 << 2)
             + (d1 << 3) + (d1 << 1)
             + d0;
    endfunction

endpackage

// File: rtl/sseg_capture_if.sv
// Display bus plus captured-frame reporting for sseg_capture.
interface sseg_capture_if;
    import sseg_pkg::*;

    logic [AN_W-1:0]  Anode_Activate_in;
    logic [SEG_W-1:0] LED_in;
    logic [BCD_W-1:0] captured_bcd;
    logic [BIN_W-1:0] captured_number;
    logic             number_valid;
    logic             frame_error;
    logic             display_blank;

    modport master (
        output Anode_Activate_in, LED_in,
        input  captured_bcd, captured_number, number_valid, frame_error, display_blank
    );

    modport slave (
        input  Anode_Activate_in, LED_in,
        output captured_bcd, captured_number, number_valid, frame_error, display_blank
    );
endinterface

// File: rtl/sseg_segment_decode.sv
// Combinational active-low cathode pattern to BCD digit decoder.
module sseg_segment_decode
    import sseg_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic             valid_c,
    output logic [DIG_W-1:0] digit_c
);

    always_comb begin
        valid_c = 1'b1;
        digit_c = '0;
        case (seg)
            SEG_0:   digit_c = 4'd0;
            SEG_1:   digit_c = 4'd1;
            SEG_2:   digit_c = 4'd2;
            SEG_3:   digit_c = 4'd3;
            SEG_4:   digit_c = 4'd4;
            SEG_5:   digit_c = 4'd5;
            SEG_6:   digit_c = 4'd6;
            SEG_7:   digit_c = 4'd7;
            SEG_8:   digit_c = 4'd8;
            SEG_9:   digit_c = 4'd9;
            default: valid_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/sseg_capture.sv
// Captures four-digit frames from a multiplexed seven-segment bus.
// Optional SSEG_CAPTURE_CONSISTENCY_EN: accept a frame only when it repeats the previous one.
module sseg_capture
    import sseg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
)
(
    input  logic          clock_100Mhz,
    input  logic          reset_n,
    sseg_capture_if.slave sseg
);

    localparam int unsigned STAB_W = 16;
    localparam int unsigned TMO_W  = 25;
    localparam logic [STAB_W-1:0] STAB_HIT = STAB_W'(SETTLE_CYCLES - 2);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

    sseg_bus_t         bus_m;
    sseg_bus_t         bus_s;
    sseg_bus_t         bus_p;
    logic [STAB_W-1:0] stab_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              bus_changed_c;
    logic              stab_hit_c;
    logic              pos_valid_c;
    logic [1:0]        pos_c;
    logic              dig_valid_c;
    logic [DIG_W-1:0]  digit_c;
    logic              sample_c;
    logic              tmo_fire_c;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [1:0]        exp_pos;
    logic [1:0]        exp_pos_nx;
    logic [BCD_W-1:0]  frame_bcd;
    logic [BCD_W-1:0]  frame_bcd_nx;
    logic              err_c;
    logic              load_c;
    logic              accept_c;

    logic [BCD_W-1:0]  cap_bcd;
    logic [BIN_W-1:0]  cap_number;
    logic              number_valid;
    logic              frame_error;
    logic              display_blank;

    // Two-flop synchronizer plus a history stage for change detection
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            bus_m <= {AN_IDLE, SEG_BLANK};
            bus_s <= {AN_IDLE, SEG_BLANK};
            bus_p <= {AN_IDLE, SEG_BLANK};
        end else begin
            bus_m <= {sseg.Anode_Activate_in, sseg.LED_in};
            bus_s <= bus_m;
            bus_p <= bus_s;
        end
    end

    assign bus_changed_c = (bus_s != bus_p);
    assign stab_hit_c    = !bus_changed_c && (stab_cnt == STAB_HIT);

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            stab_cnt <= '0;
        end else if (bus_changed_c) begin
            stab_cnt <= '0;
        end else if (stab_cnt != '1) begin
            stab_cnt <= stab_cnt + STAB_W'(1);
        end
    end

    // Digit position 3 = thousands ... 0 = units; any other anode value is idle
    always_comb begin
        pos_valid_c = 1'b1;
        pos_c       = 2'd0;
        case (bus_s.anode)
            AN_THOUSANDS: pos_c = 2'd3;
            AN_HUNDREDS:  pos_c = 2'd2;
            AN_TENS:      pos_c = 2'd1;
            AN_UNITS:     pos_c = 2'd0;
            default:      pos_valid_c = 1'b0;
        endcase
    end

    sseg_segment_decode u_decode (
        .seg     (bus_s.seg),
        .valid_c (dig_valid_c),
        .digit_c (digit_c)
    );

    assign sample_c   = stab_hit_c && pos_valid_c;
    assign tmo_fire_c = !sample_c && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt       <= '0;
            display_blank <= 1'b0;
        end else if (sample_c) begin
            tmo_cnt       <= '0;
            display_blank <= 1'b0;
        end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_fire_c) begin
                display_blank <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        exp_pos_nx   = exp_pos;
        frame_bcd_nx = frame_bcd;
        err_c        = 1'b0;
        load_c       = 1'b0;
        case (state)
            WAIT_START: begin
                if (sample_c && (pos_c == 2'd3) && dig_valid_c) begin
                    frame_bcd_nx[15:12] = digit_c;
                    exp_pos_nx          = 2'd2;
                    state_nx            = COLLECT;
                end
            end
            COLLECT: begin
                if (sample_c) begin
                    if ((pos_c != exp_pos) || !dig_valid_c) begin
                        err_c    = 1'b1;
                        state_nx = WAIT_START;
                    end else begin
                        frame_bcd_nx[{exp_pos, 2'b00} +: DIG_W] = digit_c;
                        if (exp_pos == 2'd0) begin
                            state_nx = CONVERT;
                        end else begin
                            exp_pos_nx = exp_pos - 2'd1;
                        end
                    end
                end
            end
            CONVERT: begin
                load_c   = 1'b1;
                state_nx = WAIT_START;
            end
            default: state_nx = WAIT_START;
        endcase
        if (tmo_fire_c) begin
            state_nx = WAIT_START;
        end
    end

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state       <= WAIT_START;
            exp_pos     <= 2'd2;
            frame_bcd   <= '0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_nx;
            exp_pos     <= exp_pos_nx;
            frame_bcd   <= frame_bcd_nx;
            frame_error <= err_c;
        end
    end

`ifdef SSEG_CAPTURE_CONSISTENCY_EN
    logic             cand_valid;
    logic [BCD_W-1:0] cand_bcd;

    assign accept_c = load_c && cand_valid && (cand_bcd == frame_bcd);

    // Candidate is the last converted frame; a timeout forgets it
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            cand_valid <= 1'b0;
            cand_bcd   <= '0;
        end else if (tmo_fire_c) begin
            cand_valid <= 1'b0;
        end else if (load_c) begin
            cand_valid <= 1'b1;
            cand_bcd   <= frame_bcd;
        end
    end
`else
    assign accept_c = load_c;
`endif

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            cap_bcd      <= '0;
            cap_number   <= '0;
            number_valid <= 1'b0;
        end else begin
            number_valid <= accept_c;
            if (accept_c) begin
                cap_bcd    <= frame_bcd;
                cap_number <= bcd_to_bin(frame_bcd);
            end
        end
    end

    assign sseg.captured_bcd    = cap_bcd;
    assign sseg.captured_number = cap_number;
    assign sseg.number_valid    = number_valid;
    assign sseg.frame_error     = frame_error;
    assign sseg.display_blank   = display_blank;

endmodule

// File: tb/tb_sseg_capture.sv
// Directed table-driven bench for sseg_capture with short settle/timeout values.
module tb_sseg_capture;

    localparam int DWELL = 64;
    localparam logic [3:0] AN_T = 4'b0111;
    localparam logic [3:0] AN_H = 4'b1011;
    localparam logic [3:0] AN_N = 4'b1101;
    localparam logic [3:0] AN_U = 4'b1110;
    localparam logic [3:0] AN_I = 4'b1111;

    typedef struct {
        string       name;
        logic [3:0]  an [5];
        logic [6:0]  sg [5];
        int          exp_nv;
        int          exp_fe;
        logic [15:0] exp_bcd;
        logic [13:0] exp_num;
    } vec_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   nv_cnt;
    int   fe_cnt;
    int   nv_cyc;
    int   units_cyc;
    int   n_checks;
    int   n_errors;

    sseg_capture_if bus ();

    sseg_capture #(
        .SETTLE_CYCLES  (16),
        .TIMEOUT_CYCLES (4096)
    ) dut (
        .clock_100Mhz (clk),
        .reset_n      (rst_n),
        .sseg         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus.number_valid) begin
            nv_cnt = nv_cnt + 1;
            nv_cyc = cyc;
        end
        if (rst_n && bus.frame_error) fe_cnt = fe_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            10: return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic vec_t mkv(input string nm,
                                 input logic [3:0] a0, input int d0,
                                 input logic [3:0] a1, input int d1,
                                 input logic [3:0] a2, input int d2,
                                 input logic [3:0] a3, input int d3,
                                 input logic [3:0] a4, input int d4,
                                 input int nv, input int fe,
                                 input logic [15:0] bcd, input logic [13:0] num);
        vec_t v;
        v.name = nm;
        v.an[0] = a0; v.sg[0] = seg_of(d0);
        v.an[1] = a1; v.sg[1] = seg_of(d1);
        v.an[2] = a2; v.sg[2] = seg_of(d2);
        v.an[3] = a3; v.sg[3] = seg_of(d3);
        v.an[4] = a4; v.sg[4] = seg_of(d4);
        v.exp_nv = nv; v.exp_fe = fe; v.exp_bcd = bcd; v.exp_num = num;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive_step(input logic [3:0] an, input logic [6:0] sg);
        @(posedge clk);
        #1;
        bus.Anode_Activate_in = an;
        bus.LED_in            = sg;
        if (an == AN_U) units_cyc = cyc;
        repeat (DWELL - 1) @(posedge clk);
    endtask

    task automatic send_frame(input int d3, input int d2, input int d1, input int d0);
        drive_step(AN_T, seg_of(d3));
        drive_step(AN_H, seg_of(d2));
        drive_step(AN_N, seg_of(d1));
        drive_step(AN_U, seg_of(d0));
        drive_step(AN_I, seg_of(-1));
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    vec_t vecs [10];
    int   nv0;
    int   fe0;
    int   t0;

    initial begin
        n_checks = 0; n_errors = 0; nv_cnt = 0; fe_cnt = 0; cyc = 0; nv_cyc = 0; units_cyc = 0;
        rst_n = 1'b0;
        bus.Anode_Activate_in = AN_I;
        bus.LED_in            = 7'b1111111;

        vecs[0] = mkv("f0123",    AN_T,0,  AN_H,1,  AN_N,2,  AN_U,3,  AN_I,-1, 1,0,16'h0123,14'd123);
        vecs[1] = mkv("f9999",    AN_T,9,  AN_H,9,  AN_N,9,  AN_U,9,  AN_I,-1, 1,0,16'h9999,14'd9999);
        vecs[2] = mkv("f0123b",   AN_T,0,  AN_H,1,  AN_N,2,  AN_U,3,  AN_I,-1, 1,0,16'h0123,14'd123);
        vecs[3] = mkv("blank_tens",AN_T,4, AN_H,5,  AN_N,-1, AN_U,7,  AN_I,-1, 0,1,16'h0123,14'd123);
        vecs[4] = mkv("skip_hund",AN_T,8,  AN_N,1,  AN_H,2,  AN_U,3,  AN_I,-1, 0,1,16'h0123,14'd123);
        vecs[5] = mkv("f0042",    AN_T,0,  AN_H,0,  AN_N,4,  AN_U,2,  AN_I,-1, 1,0,16'h0042,14'd42);
        vecs[6] = mkv("repeat_h", AN_T,1,  AN_H,2,  AN_H,3,  AN_N,4,  AN_U,5,  0,1,16'h0042,14'd42);
        vecs[7] = mkv("bad_start",AN_T,-1, AN_T,1,  AN_H,2,  AN_N,3,  AN_U,4,  1,0,16'h1234,14'd1234);
        vecs[8] = mkv("bad_seg",  AN_T,5,  AN_H,10, AN_N,0,  AN_U,0,  AN_I,-1, 0,1,16'h1234,14'd1234);
        vecs[9] = mkv("f5080",    AN_T,5,  AN_H,0,  AN_N,8,  AN_U,0,  AN_I,-1, 1,0,16'h5080,14'd5080);

        repeat (5) @(negedge clk);
        check("rst_bcd",   32'(bus.captured_bcd), 32'h0);
        check("rst_num",   32'(bus.captured_number), 32'd0);
        check("rst_nv",    32'(bus.number_valid), 32'd0);
        check("rst_fe",    32'(bus.frame_error), 32'd0);
        check("rst_blank", 32'(bus.display_blank), 32'd0);
        rst_n = 1'b1;

`ifndef SSEG_CAPTURE_CONSISTENCY_EN
        for (int i = 0; i < 10; i++) begin
            nv0 = nv_cnt;
            fe0 = fe_cnt;
            for (int s = 0; s < 5; s++) drive_step(vecs[i].an[s], vecs[i].sg[s]);
            @(negedge clk);
            check({vecs[i].name, "_nv"},    32'(nv_cnt - nv0), 32'(vecs[i].exp_nv));
            check({vecs[i].name, "_fe"},    32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
            check({vecs[i].name, "_bcd"},   32'(bus.captured_bcd), 32'(vecs[i].exp_bcd));
            check({vecs[i].name, "_num"},   32'(bus.captured_number), 32'(vecs[i].exp_num));
            check({vecs[i].name, "_blank"}, 32'(bus.display_blank), 32'd0);
            if (vecs[i].exp_nv == 1)
                check({vecs[i].name, "_nv_lat"},
                      32'((nv_cyc - units_cyc >= 17 && nv_cyc - units_cyc <= 22) ? 1 : 0), 32'd1);
        end
`else
        nv0 = nv_cnt;
        send_frame(0, 1, 2, 3);
        check("cons_first_nv",  32'(nv_cnt - nv0), 32'd0);
        check("cons_first_bcd", 32'(bus.captured_bcd), 32'h0);
        send_frame(0, 1, 2, 3);
        check("cons_second_nv",  32'(nv_cnt - nv0), 32'd1);
        check("cons_second_bcd", 32'(bus.captured_bcd), 32'h0123);
        check("cons_second_num", 32'(bus.captured_number), 32'd123);
        nv0 = nv_cnt;
        send_frame(0, 0, 4, 2);
        check("cons_change_nv",  32'(nv_cnt - nv0), 32'd0);
        check("cons_change_num", 32'(bus.captured_number), 32'd123);
        send_frame(0, 0, 4, 2);
        check("cons_repeat_nv",  32'(nv_cnt - nv0), 32'd1);
        check("cons_repeat_num", 32'(bus.captured_number), 32'd42);
`endif

        // Thousands accepted, then an idle bus long enough to time out mid-frame
        nv0 = nv_cnt;
        fe0 = fe_cnt;
        t0  = cyc + 1;
        drive_step(AN_T, seg_of(1));
        @(posedge clk);
        #1;
        bus.Anode_Activate_in = AN_I;
        bus.LED_in            = seg_of(-1);
        wait_until(t0 + 4105);
        check("tmo_before", 32'(bus.display_blank), 32'd0);
        wait_until(t0 + 4125);
        check("tmo_after", 32'(bus.display_blank), 32'd1);
        wait_until(t0 + 5064);
        check("tmo_hold", 32'(bus.display_blank), 32'd1);
        check("tmo_fe",   32'(fe_cnt - fe0), 32'd0);
        drive_step(AN_N, seg_of(5));
        @(negedge clk);
        check("tmo_clear",    32'(bus.display_blank), 32'd0);
        check("tmo_wait_fe",  32'(fe_cnt - fe0), 32'd0);
        check("tmo_nv",       32'(nv_cnt - nv0), 32'd0);

`ifndef SSEG_CAPTURE_CONSISTENCY_EN
        // Reset during the hundreds dwell discards the partial frame
        drive_step(AN_T, seg_of(7));
        @(posedge clk);
        #1;
        bus.Anode_Activate_in = AN_H;
        bus.LED_in            = seg_of(7);
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_bcd",   32'(bus.captured_bcd), 32'h0);
        check("mid_rst_num",   32'(bus.captured_number), 32'd0);
        check("mid_rst_nv",    32'(bus.number_valid), 32'd0);
        check("mid_rst_fe",    32'(bus.frame_error), 32'd0);
        check("mid_rst_blank", 32'(bus.display_blank), 32'd0);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        nv0 = nv_cnt;
        fe0 = fe_cnt;
        drive_step(AN_N, seg_of(7));
        drive_step(AN_U, seg_of(7));
        drive_step(AN_I, seg_of(-1));
        check("post_rst_partial_nv", 32'(nv_cnt - nv0), 32'd0);
        check("post_rst_partial_fe", 32'(fe_cnt - fe0), 32'd0);
        send_frame(0, 1, 0, 0);
        check("post_rst_nv",  32'(nv_cnt - nv0), 32'd1);
        check("post_rst_num", 32'(bus.captured_number), 32'd100);
        check("post_rst_bcd", 32'(bus.captured_bcd), 32'h0100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
